bram_wr_arbiter: RTL and testbench

Write-port controller for the simple-dual-port block RAM: shares the single write port between two independent write requesters using round-robin arbitration, and adds a clear engine that fills the whole memory with a constant value. All outputs to the RAM write port are registered. The block sits in the write clock domain in front of the RAM; the RAM read port is not touched.

---
 rtl/bram_wr_arbiter.sv | 133 +++++++++++++
 tb/tb_bram_wr_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_wr_arbiter.sv
// Write-port controller for a simple-dual-port BRAM: round-robin sharing of the write
// port between two requesters, plus a clear engine that fills the memory with one value.
module bram_wr_arbiter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 256,
  localparam int unsigned ADDRW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [ADDRW-1:0] req0_addr,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [ADDRW-1:0] req1_addr,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  input  logic             clr_start,
  input  logic [WIDTH-1:0] clr_value,
  output logic             clr_busy,
  output logic             clr_done,
  output logic             bram_we,
  output logic [ADDRW-1:0] bram_addr,
  output logic [WIDTH-1:0] bram_data
);

  // One extra counter bit so the terminal count DEPTH is representable.
  localparam int unsigned CW = ADDRW + 1;
  localparam logic [CW-1:0] CNT_END = CW'(DEPTH);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] clr_val_q, clr_val_d;
  logic             last_q, last_d;   // 0: requester 0 granted last, 1: requester 1
  logic             we_d;
  logic [ADDRW-1:0] addr_d;
  logic [WIDTH-1:0] data_d;
  logic             busy_d, done_d;
  logic             grant0, grant1;

  // Round-robin: a lone requester wins; on a tie the one not granted last wins.
  assign grant0 = req0_valid && (!req1_valid || last_q);
  assign grant1 = req1_valid && (!req0_valid || !last_q);

  // Next-state, handshake and next-output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clr_val_d  = clr_val_q;
    last_d     = last_q;
    we_d       = 1'b0;
    addr_d     = bram_addr;
    data_d     = bram_data;
    busy_d     = clr_busy;
    done_d     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (clr_start) begin
          // Address 0 is issued on the same edge that enters CLEAR.
          state_d   = ST_CLEAR;
          clr_val_d = clr_value;
          cnt_d     = CW'(1);
          we_d      = 1'b1;
          addr_d    = '0;
          data_d    = clr_value;
          busy_d    = 1'b1;
        end else if (grant0) begin
          req0_ready = 1'b1;
          last_d     = 1'b0;
          we_d       = 1'b1;
          addr_d     = req0_addr;
          data_d     = req0_data;
        end else if (grant1) begin
          req1_ready = 1'b1;
          last_d     = 1'b1;
          we_d       = 1'b1;
          addr_d     = req1_addr;
          data_d     = req1_data;
        end
      end
      ST_CLEAR: begin
        if (cnt_q == CNT_END) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          we_d   = 1'b1;
          addr_d = cnt_q[ADDRW-1:0];
          data_d = clr_val_q;
          cnt_d  = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered RAM-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      clr_val_q <= '0;
      last_q    <= 1'b1;
      bram_we   <= 1'b0;
      bram_addr <= '0;
      bram_data <= '0;
      clr_busy  <= 1'b0;
      clr_done  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      clr_val_q <= clr_val_d;
      last_q    <= last_d;
      bram_we   <= we_d;
      bram_addr <= addr_d;
      bram_data <= data_d;
      clr_busy  <= busy_d;
      clr_done  <= done_d;
    end
  end

endmodule

// File: tb/tb_bram_wr_arbiter.sv
// Self-checking bench for bram_wr_arbiter: directed scenarios plus a randomized run
// against a schedule-based reference model and a RAM model.
module tb_bram_wr_arbiter;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned ADDRW = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req1_valid;
  logic [ADDRW-1:0] req0_addr, req1_addr;
  logic [WIDTH-1:0] req0_data, req1_data;
  logic             req0_ready, req1_ready;
  logic             clr_start;
  logic [WIDTH-1:0] clr_value;
  logic             clr_busy, clr_done;
  logic             bram_we;
  logic [ADDRW-1:0] bram_addr;
  logic [WIDTH-1:0] bram_data;

  int n_cmp = 0;
  int n_fail = 0;

  logic [WIDTH-1:0] ram     [DEPTH];
  logic [WIDTH-1:0] exp_mem [DEPTH];

  // {we, addr, data, busy, done}
  logic [14:0] outs;
  assign outs = {bram_we, bram_addr, bram_data, clr_busy, clr_done};

  bram_wr_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .clr_start(clr_start), .clr_value(clr_value), .clr_busy(clr_busy), .clr_done(clr_done),
    .bram_we(bram_we), .bram_addr(bram_addr), .bram_data(bram_data)
  );

  always #5 clk = ~clk;

  // RAM write port model.
  always @(posedge clk) if (bram_we === 1'b1) ram[bram_addr] <= bram_data;

  function automatic logic [14:0] mk(input logic we, input logic [3:0] a, input logic [7:0] d,
                                     input logic b, input logic dn);
    return {we, a, d, b, dn};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic fill_exp(input logic [7:0] v);
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = v;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    n_cmp++;
    if (outs !== 15'h0) begin n_fail++; $display("FAIL reset_async_outs got %h want %h", outs, 15'h0); end
    step();
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      n_fail++; $display("FAIL reset_ready got %b want 00", {req0_ready, req1_ready});
    end
  endtask

  task automatic test_single();
    req0_valid = 1'b1; req0_addr = 4'd3; req0_data = 8'hA5;
    #1;
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_fail++; $display("FAIL single_ready got %b want 10", {req0_ready, req1_ready});
    end
    step();
    req0_valid = 1'b0;
    n_cmp++;
    if (outs !== mk(1, 3, 8'hA5, 0, 0)) begin
      n_fail++; $display("FAIL single_write got %h want %h", outs, mk(1, 3, 8'hA5, 0, 0));
    end
    step();
    n_cmp++;
    if (outs !== mk(0, 3, 8'hA5, 0, 0)) begin
      n_fail++; $display("FAIL single_idle got %h want %h", outs, mk(0, 3, 8'hA5, 0, 0));
    end
    exp_mem[3] = 8'hA5;
  endtask

  task automatic test_contention();
    int cnt0, cnt1;
    logic [1:0] want;
    cnt0 = 0; cnt1 = 0;
    pulse_reset();
    req0_addr = 4'($urandom); req0_data = 8'($urandom);
    req1_addr = 4'($urandom); req1_data = 8'($urandom);
    for (int c = 0; c < 6; c++) begin
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      want = (c % 2 == 0) ? 2'b10 : 2'b01;
      n_cmp++;
      if ({req0_ready, req1_ready} !== want) begin
        n_fail++; $display("FAIL contention_grant c=%0d got %b want %b", c, {req0_ready, req1_ready}, want);
      end
      if (req0_ready === 1'b1) cnt0++;
      if (req1_ready === 1'b1) cnt1++;
      step();
      n_cmp++;
      if (want[1]) begin
        if (outs !== mk(1, req0_addr, req0_data, 0, 0)) begin
          n_fail++; $display("FAIL contention_write c=%0d got %h want %h", c, outs, mk(1, req0_addr, req0_data, 0, 0));
        end
        exp_mem[req0_addr] = req0_data;
        req0_addr = 4'($urandom); req0_data = 8'($urandom);
      end else begin
        if (outs !== mk(1, req1_addr, req1_data, 0, 0)) begin
          n_fail++; $display("FAIL contention_write c=%0d got %h want %h", c, outs, mk(1, req1_addr, req1_data, 0, 0));
        end
        exp_mem[req1_addr] = req1_data;
        req1_addr = 4'($urandom); req1_data = 8'($urandom);
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    n_cmp++;
    if (cnt0 !== 3 || cnt1 !== 3) begin
      n_fail++; $display("FAIL contention_count got %0d/%0d want 3/3", cnt0, cnt1);
    end
    step();
    n_cmp++;
    if (bram_we !== 1'b0) begin n_fail++; $display("FAIL contention_end_we got %b want 0", bram_we); end
  endtask

  task automatic test_clear();
    clr_start = 1'b1; clr_value = 8'h5A;
    step();
    clr_start = 1'b0; clr_value = 8'hFF;
    for (int k = 0; k < DEPTH; k++) begin
      // A second start while busy must be ignored.
      clr_start = (k == 5);
      n_cmp++;
      if (outs !== mk(1, 4'(k), 8'h5A, 1, 0)) begin
        n_fail++; $display("FAIL clear_word k=%0d got %h want %h", k, outs, mk(1, 4'(k), 8'h5A, 1, 0));
      end
      step();
      clr_start = 1'b0;
    end
    n_cmp++;
    if (outs !== mk(0, 4'd15, 8'h5A, 0, 1)) begin
      n_fail++; $display("FAIL clear_done got %h want %h", outs, mk(0, 4'd15, 8'h5A, 0, 1));
    end
    step();
    n_cmp++;
    if (outs !== mk(0, 4'd15, 8'h5A, 0, 0)) begin
      n_fail++; $display("FAIL clear_after got %h want %h", outs, mk(0, 4'd15, 8'h5A, 0, 0));
    end
    fill_exp(8'h5A);
    for (int i = 0; i < DEPTH; i++) begin
      n_cmp++;
      if (ram[i] !== 8'h5A) begin n_fail++; $display("FAIL clear_ram[%0d] got %h want 5a", i, ram[i]); end
    end
  endtask

  task automatic test_clear_priority();
    req1_valid = 1'b1; req1_addr = 4'd9; req1_data = 8'h3C;
    clr_start = 1'b1; clr_value = 8'h11;
    #1;
    n_cmp++;
    if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL prio_start_ready got %b want 0", req1_ready); end
    step();
    clr_start = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      n_cmp++;
      if ({req1_ready, outs} !== {1'b0, mk(1, 4'(k), 8'h11, 1, 0)}) begin
        n_fail++; $display("FAIL prio_clear k=%0d got %b/%h want 0/%h", k, req1_ready, outs, mk(1, 4'(k), 8'h11, 1, 0));
      end
      step();
    end
    n_cmp++;
    if ({req0_ready, req1_ready, clr_done} !== 3'b011) begin
      n_fail++; $display("FAIL prio_done_ready got %b want 011", {req0_ready, req1_ready, clr_done});
    end
    step();
    req1_valid = 1'b0;
    n_cmp++;
    if (outs !== mk(1, 4'd9, 8'h3C, 0, 0)) begin
      n_fail++; $display("FAIL prio_write got %h want %h", outs, mk(1, 4'd9, 8'h3C, 0, 0));
    end
    fill_exp(8'h11);
    exp_mem[9] = 8'h3C;
  endtask

  task automatic test_reset_mid_clear();
    clr_start = 1'b1; clr_value = 8'h77;
    step();
    clr_start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      exp_mem[k] = 8'h77;
      step();
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (outs !== 15'h0) begin n_fail++; $display("FAIL midrst_outs got %h want %h", outs, 15'h0); end
    step();
    n_cmp++;
    if (outs !== 15'h0) begin n_fail++; $display("FAIL midrst_hold got %h want %h", outs, 15'h0); end
    rst = 1'b0;
    req0_valid = 1'b1; req0_addr = 4'd12; req0_data = 8'hE1;
    #1;
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_fail++; $display("FAIL midrst_ready got %b want 10", {req0_ready, req1_ready});
    end
    step();
    req0_valid = 1'b0;
    n_cmp++;
    if (outs !== mk(1, 4'd12, 8'hE1, 0, 0)) begin
      n_fail++; $display("FAIL midrst_write got %h want %h", outs, mk(1, 4'd12, 8'hE1, 0, 0));
    end
    exp_mem[12] = 8'hE1;
    step();
    for (int i = 0; i < DEPTH; i++) begin
      n_cmp++;
      if (ram[i] !== exp_mem[i]) begin
        n_fail++; $display("FAIL midrst_ram[%0d] got %h want %h", i, ram[i], exp_mem[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    clr_start = 1'b1; clr_value = 8'h21;
    step();
    clr_start = 1'b0;
    repeat (DEPTH) step();
    n_cmp++;
    if (outs !== mk(0, 4'd15, 8'h21, 0, 1)) begin
      n_fail++; $display("FAIL b2b_done1 got %h want %h", outs, mk(0, 4'd15, 8'h21, 0, 1));
    end
    clr_start = 1'b1; clr_value = 8'h42;
    step();
    clr_start = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      n_cmp++;
      if (outs !== mk(1, 4'(k), 8'h42, 1, 0)) begin
        n_fail++; $display("FAIL b2b_word k=%0d got %h want %h", k, outs, mk(1, 4'(k), 8'h42, 1, 0));
      end
      step();
    end
    n_cmp++;
    if (outs !== mk(0, 4'd15, 8'h42, 0, 1)) begin
      n_fail++; $display("FAIL b2b_done2 got %h want %h", outs, mk(0, 4'd15, 8'h42, 0, 1));
    end
    fill_exp(8'h42);
    step();
  endtask

  task automatic test_random();
    logic [14:0] sched[$];
    logic [14:0] nxt, prev;
    int          last;
    logic        p0, p1, g0, g1;
    logic [3:0]  a0, a1;
    logic [7:0]  d0, d1;
    pulse_reset();
    prev = '0; last = 1; p0 = 1'b0; p1 = 1'b0;
    a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    for (int c = 0; c < 400; c++) begin
      if (!p0 && $urandom_range(0, 1) == 1) begin p0 = 1'b1; a0 = 4'($urandom); d0 = 8'($urandom); end
      if (!p1 && $urandom_range(0, 2) != 0) begin p1 = 1'b1; a1 = 4'($urandom); d1 = 8'($urandom); end
      req0_valid = p0; req0_addr = a0; req0_data = d0;
      req1_valid = p1; req1_addr = a1; req1_data = d1;
      clr_start = ($urandom_range(0, 39) == 0);
      clr_value = 8'($urandom);
      #1;
      g0 = 1'b0; g1 = 1'b0;
      if (sched.size() == 0 && !clr_start) begin
        if (p0 && (!p1 || last == 1)) g0 = 1'b1;
        else if (p1) g1 = 1'b1;
      end
      n_cmp++;
      if ({req0_ready, req1_ready} !== {g0, g1}) begin
        n_fail++; $display("FAIL rand_ready c=%0d got %b want %b", c, {req0_ready, req1_ready}, {g0, g1});
      end
      if (sched.size() != 0) begin
        nxt = sched.pop_front();
      end else if (clr_start) begin
        nxt = mk(1, 4'd0, clr_value, 1, 0);
        for (int k = 1; k < DEPTH; k++) sched.push_back(mk(1, 4'(k), clr_value, 1, 0));
        sched.push_back(mk(0, 4'd15, clr_value, 0, 1));
        fill_exp(clr_value);
      end else if (g0) begin
        nxt = mk(1, a0, d0, 0, 0); exp_mem[a0] = d0; last = 0; p0 = 1'b0;
      end else if (g1) begin
        nxt = mk(1, a1, d1, 0, 0); exp_mem[a1] = d1; last = 1; p1 = 1'b0;
      end else begin
        nxt = mk(0, prev[13:10], prev[9:2], 0, 0);
      end
      step();
      n_cmp++;
      if (outs !== nxt) begin
        n_fail++; $display("FAIL rand_outs c=%0d got %h want %h", c, outs, nxt);
      end
      prev = nxt;
    end
    req0_valid = 1'b0; req1_valid = 1'b0; clr_start = 1'b0;
    repeat (DEPTH + 2) step();
    for (int i = 0; i < DEPTH; i++) begin
      n_cmp++;
      if (ram[i] !== exp_mem[i]) begin
        n_fail++; $display("FAIL rand_ram[%0d] got %h want %h", i, ram[i], exp_mem[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    clr_start = 1'b0; clr_value = '0;
    test_reset();
    test_single();
    test_contention();
    test_clear();
    test_clear_priority();
    test_reset_mid_clear();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
